pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter PC_W, default 32, PC width in bits.
REQ-002 Parameter RESET_PC, default 0, PC value loaded by reset.
REQ-003 Parameter INC, default 4, sequential increment.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, at least 2.
REQ-005 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_i  in  1  reset, synchronous and active-high.
REQ-007 start_i  in  1  run enable; low parks the unit in IDLE.
REQ-008 stall_i  in  1  freeze the PC this cycle.
REQ-009 redirect_i  in  1  load redirect_pc_i as the next PC.
REQ-010 redirect_pc_i  in  PC_W  redirect target.
REQ-011 call_i  in  1  qualifies redirect_i as a call; push the return address.
REQ-012 ret_i  in  1  next PC comes from the top of the RAS.
REQ-013 pc_o  out  PC_W  current PC.
REQ-014 pc_valid_o  out  1  pc_o is a fetchable PC this cycle.
REQ-015 pending_o  out  1  a redirect captured during a stall is waiting.
REQ-016 ras_empty_o / ras_full_o  out  1 each  RAS occupancy flags.

Function
REQ-017 States: IDLE and RUN; IDLE->RUN when start_i=1; RUN->IDLE when start_i=0; pc_o and RAS are kept across both transitions.
REQ-018 pc_valid_o=1 only in RUN with stall_i=0; the first RUN cycle presents the held pc_o.
REQ-019 IDLE: pc_o holds; redirect_i, call_i and ret_i are ignored.
REQ-020 RUN with stall_i=0: next pc_o follows this priority: redirect_i -> redirect_pc_i; else pending -> pending target; else ret_i with RAS non-empty -> pop top; else pc_o+INC.
REQ-021 ret_i with an empty RAS falls back to pc_o+INC, and the RAS stays empty.
REQ-022 redirect_i with call_i pushes pc_o+INC in the same cycle; ret_i is ignored when redirect_i=1.
REQ-023 A push when the RAS is full overwrites the oldest entry (circular), and occupancy stays at RAS_DEPTH.
REQ-024 RUN with stall_i=1: pc_o holds; redirect_i captures redirect_pc_i into the pending register (the latest capture wins); call_i and ret_i are ignored.
REQ-025 The pending register clears in the cycle its target is applied, and also when a live redirect_i overrides it.
REQ-026 All PC arithmetic is modulo 2^PC_W, so pc_o+INC wraps silently.

Reset
REQ-027 With rst_i=1 at a clock edge: state=IDLE, pc_o=RESET_PC, pending cleared, RAS emptied; all inputs are ignored that cycle.
REQ-028 Reset values: pc_valid_o=0, pending_o=0, ras_empty_o=1, ras_full_o=0.
REQ-029 Reset asserted mid-operation, including during a stall with a redirect pending, discards the pending redirect and all RAS contents.

Structure
REQ-030 Package pc_unit_pkg holds the state enum and the default parameter constants.
REQ-031 Sub-module pc_ras implements the circular stack: push, pop, top, empty and full; pointers are log2(RAS_DEPTH) bits.
REQ-032 All outputs are driven directly from registers.

Verification
REQ-033 Reset, then start_i=1 for 4 cycles -> pc_o = 0, 0, 4, 8; pc_valid_o goes 1 from the first RUN cycle.
REQ-034 At pc_o=0x100, assert redirect_i+call_i with target 0x400, then ret_i two cycles later -> pc_o = 0x400, 0x404, 0x104.
REQ-035 stall_i=1 for 3 cycles with redirect_i to 0x800 in stall cycle 2 -> pc_o held, pending_o=1; first unstalled cycle -> pc_o=0x800, pending_o=0.
REQ-036 5 calls with RAS_DEPTH=4, then 5 returns -> ras_full_o=1 after the 4th call; 4 returns yield the last 4 return addresses, and the 5th gives pc_o+INC with ras_empty_o=1.
REQ-037 pc_o=0xFFFFFFFC with a sequential step -> pc_o=0.
REQ-038 rst_i during a stall with pending_o=1 -> next cycle pc_o=RESET_PC, pending_o=0, ras_empty_o=1, state IDLE.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// ----------------------------------------------------------------------------
// pc_unit_pkg : shared state encoding and default parameters for pc_unit
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pc_unit_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned DEF_PC_W      = 32;
  localparam int unsigned DEF_RESET_PC  = 0;
  localparam int unsigned DEF_INC       = 4;
  localparam int unsigned DEF_RAS_DEPTH = 4;

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// ----------------------------------------------------------------------------
// pc_ras : circular return-address stack; a push when full drops the oldest
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_ras #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] push_data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty_q, full_q;

  // The top pointer always advances on push, so the slot it lands on when
  // full is exactly the oldest entry; only the count saturates.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (push_i) begin
      top_d = top_q + PW'(1);
      cnt_d = full_q ? cnt_q : cnt_q + CW'(1);
    end else if (pop_i && !empty_q) begin
      top_d = top_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      top_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == DEPTH_C);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !rst_i) begin
      mem_q[top_d] <= push_data_i;
    end
  end

  assign top_o   = mem_q[top_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ----------------------------------------------------------------------------
// pc_unit : program counter with stall, deferred redirect and return stack
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned     PC_W      = DEF_PC_W,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(DEF_RESET_PC),
  parameter logic [PC_W-1:0] INC       = PC_W'(DEF_INC),
  parameter int unsigned     RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            call_i,
  input  logic            ret_i,
  output logic [PC_W-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            pending_o,
  output logic            ras_empty_o,
  output logic            ras_full_o
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  logic            pend_q, pend_d;
  logic            valid_q, valid_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] ras_top;
  logic            ras_push, ras_pop;

  assign pc_inc = pc_q + INC;

  always_comb begin
    state_d   = start_i ? ST_RUN : ST_IDLE;
    valid_d   = start_i && !stall_i;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    if (state_q == ST_RUN) begin
      if (stall_i) begin
        if (redirect_i) begin
          pend_d    = 1'b1;
          pend_pc_d = redirect_pc_i;
        end
      end else if (redirect_i) begin
        pc_d     = redirect_pc_i;
        pend_d   = 1'b0;
        ras_push = call_i;
      end else if (pend_q) begin
        pc_d   = pend_pc_q;
        pend_d = 1'b0;
      end else if (ret_i && !ras_empty_o) begin
        pc_d    = ras_top;
        ras_pop = 1'b1;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      valid_q   <= valid_d;
    end
  end

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_inc),
    .top_o       (ras_top),
    .empty_o     (ras_empty_o),
    .full_o      (ras_full_o)
  );

  assign pc_o       = pc_q;
  assign pc_valid_o = valid_q;
  assign pending_o  = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_unit : vector table, directed corner sequences and random run vs model
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pc_unit;

  localparam int unsigned  PC_W      = 32;
  localparam logic [31:0]  RESET_PC  = 32'h0;
  localparam logic [31:0]  INC       = 32'h4;
  localparam int unsigned  RAS_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0, start_i = 1'b0, stall_i = 1'b0;
  logic        redirect_i = 1'b0, call_i = 1'b0, ret_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] pc_o;
  logic        pc_valid_o, pending_o, ras_empty_o, ras_full_o;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state with the RAS as a bounded queue.
  logic [31:0] m_pc, m_ppc;
  bit          m_run, m_pend, m_valid;
  logic [31:0] m_ras[$];

  always #5 clk = ~clk;

  pc_unit #(
    .PC_W      (PC_W),
    .RESET_PC  (RESET_PC),
    .INC       (INC),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .call_i        (call_i),
    .ret_i         (ret_i),
    .pc_o          (pc_o),
    .pc_valid_o    (pc_valid_o),
    .pending_o     (pending_o),
    .ras_empty_o   (ras_empty_o),
    .ras_full_o    (ras_full_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, start, stall, redir, call, ret, input logic [31:0] rpc);
    if (rst) begin
      m_run = 0; m_pc = RESET_PC; m_pend = 0; m_valid = 0;
      m_ras.delete();
      return;
    end
    if (m_run) begin
      if (stall) begin
        if (redir) begin m_pend = 1; m_ppc = rpc; end
      end else if (redir) begin
        if (call) begin
          m_ras.push_back(m_pc + INC);
          if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end
        m_pc = rpc; m_pend = 0;
      end else if (m_pend) begin
        m_pc = m_ppc; m_pend = 0;
      end else if (ret && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
      end else begin
        m_pc = m_pc + INC;
      end
    end
    m_run   = start;
    m_valid = start && !stall;
  endtask

  // Drive on the falling edge, advance the model with the same inputs at the
  // rising edge, then let outputs settle before anyone samples them.
  task automatic cyc(input bit rst, start, stall, redir, call, ret, input logic [31:0] rpc);
    @(negedge clk);
    rst_i = rst; start_i = start; stall_i = stall;
    redirect_i = redir; call_i = call; ret_i = ret; redirect_pc_i = rpc;
    @(posedge clk);
    model_step(rst, start, stall, redir, call, ret, rpc);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},    pc_o,               m_pc);
    chk({tag, ".valid"}, {31'b0, pc_valid_o}, {31'b0, m_valid});
    chk({tag, ".pend"},  {31'b0, pending_o},  {31'b0, m_pend});
    chk({tag, ".empty"}, {31'b0, ras_empty_o}, {31'b0, m_ras.size() == 0});
    chk({tag, ".full"},  {31'b0, ras_full_o},  {31'b0, m_ras.size() == RAS_DEPTH});
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input bit v, p, e, f);
    chk({tag, ".pc"},    pc_o,                pc);
    chk({tag, ".valid"}, {31'b0, pc_valid_o},  {31'b0, v});
    chk({tag, ".pend"},  {31'b0, pending_o},   {31'b0, p});
    chk({tag, ".empty"}, {31'b0, ras_empty_o}, {31'b0, e});
    chk({tag, ".full"},  {31'b0, ras_full_o},  {31'b0, f});
  endtask

  typedef struct {
    bit          rst, start, stall, redir, call, ret;
    logic [31:0] rpc;
    logic [31:0] pc;
    bit          v, p, e, f;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // rst start stall redir call ret  rpc          pc          v p e f
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 0, 1, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 1, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0, 32'h0,   32'h4,   1, 0, 1, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 0, 32'h0,   32'h8,   1, 0, 1, 0};
    tbl[4]  = '{0, 1, 0, 1, 0, 0, 32'h100, 32'h100, 1, 0, 1, 0};
    tbl[5]  = '{0, 1, 0, 1, 1, 1, 32'h400, 32'h400, 1, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 0, 32'h0,   32'h404, 1, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 0, 1, 32'h0,   32'h104, 1, 0, 1, 0};
    tbl[8]  = '{0, 1, 1, 0, 0, 0, 32'h0,   32'h104, 0, 0, 1, 0};
    tbl[9]  = '{0, 1, 1, 1, 1, 1, 32'h800, 32'h104, 0, 1, 1, 0};
    tbl[10] = '{0, 1, 1, 0, 0, 0, 32'h0,   32'h104, 0, 1, 1, 0};
    tbl[11] = '{0, 1, 0, 0, 0, 1, 32'h0,   32'h800, 1, 0, 1, 0};
    tbl[12] = '{0, 1, 0, 0, 0, 1, 32'h0,   32'h804, 1, 0, 1, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 32'h0,   32'h808, 0, 0, 1, 0};
    tbl[14] = '{0, 0, 0, 1, 1, 0, 32'h900, 32'h808, 0, 0, 1, 0};
    tbl[15] = '{0, 1, 0, 0, 0, 0, 32'h0,   32'h808, 1, 0, 1, 0};
    tbl[16] = '{0, 1, 0, 0, 0, 0, 32'h0,   32'h80C, 1, 0, 1, 0};

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].rst, tbl[i].start, tbl[i].stall, tbl[i].redir,
          tbl[i].call, tbl[i].ret, tbl[i].rpc);
      check_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].v, tbl[i].p, tbl[i].e, tbl[i].f);
    end

    // Overflowing the return stack: five calls, five returns.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 1, 0, 1, 1, 0, 32'(k) * 32'h1000);
      check_all($sformatf("call%0d", k), 32'(k) * 32'h1000, 1, 0, 0, k >= 4);
    end
    for (int j = 1; j <= 4; j++) begin
      cyc(0, 1, 0, 0, 0, 1, 0);
      check_all($sformatf("ret%0d", j), 32'(5 - j) * 32'h1000 + 32'h4, 1, 0, j == 4, 0);
    end
    cyc(0, 1, 0, 0, 0, 1, 0);
    check_all("ret5", 32'h1008, 1, 0, 1, 0);

    // Sequential step across the top of the address space.
    cyc(0, 1, 0, 1, 0, 0, 32'hFFFF_FFFC);
    check_all("wrap.pre", 32'hFFFF_FFFC, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    check_all("wrap", 32'h0, 1, 0, 1, 0);

    // Reset while stalled with a redirect pending and a non-empty stack.
    cyc(0, 1, 0, 1, 1, 0, 32'h2000);
    cyc(0, 1, 1, 1, 0, 0, 32'h3000);
    check_all("rststall.pre", 32'h2000, 0, 1, 0, 0);
    cyc(1, 1, 1, 1, 1, 1, 32'h5000);
    check_all("rststall", RESET_PC, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 32'h6000);
    check_all("rststall.idle", RESET_PC, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    check_all("rststall.run", RESET_PC, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 1, 0);
    check_all("rststall.step", RESET_PC + INC, 1, 0, 1, 0);

    // Random run against the reference model.
    cyc(1, 0, 0, 0, 0, 0, 0);
    check_model("rnd.rst");
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(63) == 0,
          $urandom_range(7) != 0,
          $urandom_range(3) == 0,
          $urandom_range(3) == 0,
          $urandom_range(1) == 1,
          $urandom_range(2) == 0,
          $urandom & 32'hFFFF_FFFC);
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
